overlay_rom_sequencer: RTL
==========================

# overlay_rom_sequencer

Video-timing-driven controller for the HDMI overlay path. Tracks the pixel position of the incoming video stream and generates read addresses for the 1-bit overlay bitmap ROM while the position lies inside a programmable window. Delay-matches the video to the ROM read latency and replaces in-window pixels with the expanded bitmap bit: 24'hFFFFFF for 1, 24'h000000 for 0. Sits between the video timing source and the HDMI transmitter, and owns both the overlay ROM address port and the bit-expansion step.

## Interface
- OVL_W, 64: bitmap width in pixels (power of two)
- OVL_H, 32: bitmap height in lines
- ADDR_W, 11: ROM address width; OVL_W*OVL_H must not exceed 2^ADDR_W
- ROM_LAT, 1: ROM read latency in clocks (1..4)

Ports:
- clk  in  1  pixel clock (single clock domain)
- rst_n  in  1  asynchronous active-low reset
- vid_de  in  1  active-video qualifier, active high
- vid_hs  in  1  hsync, active high
- vid_vs  in  1  vsync, active high
- vid_data  in  24  input pixel, RGB888
- ovl_en  in  1  overlay enable
- ovl_x  in  12  window left column
- ovl_y  in  12  window top line
- rom_addr  out  ADDR_W  bitmap ROM address
- rom_rd  out  1  ROM read strobe, high when rom_addr is valid
- rom_q  in  1  ROM data, valid ROM_LAT clocks after rom_rd
- out_de / out_hs / out_vs  out  1 each  delayed timing
- out_data  out  24  output pixel
- ovl_act  out  1  high on output pixels taken from the bitmap

## Operation
- Position counters: x = count of vid_de-high cycles since the last de rising edge, with x=0 on the first active pixel. y = count of de falling edges since the last vs rising edge. Both are 12 bits and saturate at 4095.
- Shadow registers: ovl_en, ovl_x and ovl_y are captured on each vs rising edge. Mid-frame changes take effect in the next frame.
- FSM states:
  - WAIT_FRAME: reset state. Output is passthrough only. Leaves on the first vs rising edge, going to SCAN.
  - SCAN: moves to DRAW at a de rising edge when shadow_en=1 and y == shadow_y.
  - DRAW: lines inside the window rows. line_base starts at 0 and advances by OVL_W on each de falling edge. Moves to DONE after the de falling edge that ends line OVL_H-1.
  - DONE: no ROM reads for the rest of the frame.
  - Any vs rising edge forces SCAN, including one that arrives early or mid-line. It clears x, y and line_base.
- In-window pixel: state DRAW, vid_de=1, and shadow_x <= x < shadow_x+OVL_W, where the comparison is 13-bit with no wrap. A window that extends past the right or bottom edge is clipped. Off-screen bitmap pixels are never read.
- rom_addr = line_base + (x - shadow_x), truncated to ADDR_W. rom_rd = in-window flag.
- Output mux: if the in-window flag is set, out_data = {24{rom_q}}. Otherwise out_data = vid_data, delayed to match.

## Timing
- Inputs sampled at edge n produce:
  - rom_addr/rom_rd, registered, at edge n+1.
  - rom_q valid at edge n+1+ROM_LAT.
  - out_* and ovl_act, registered, at edge n+2+ROM_LAT. Default latency is 3 clocks.
- vid_de/hs/vs/data and the in-window flag pass through a ROM_LAT+1 stage delay line. All out_* signals share identical latency, so sync alignment is preserved.
- On rst_n low, asynchronously:
  - all outputs, delay stages, counters, shadow registers and line_base go to 0;
  - rom_rd=0 and out_data=0;
  - state = WAIT_FRAME.
- Reset released mid-frame: passthrough output, no ROM reads until the next vs rising edge.
- ovl_en=0 at the vs edge: no ROM reads that frame, and out_data equals vid_data delayed.

## Test plan
- Basic window: OVL_W=8, OVL_H=4, 16x8 active frame, ovl_x=4, ovl_y=2, ROM holds a checkerboard.
  - Required: rom_addr runs 0..7 on line 2 at x=4..11, 8..15 on line 3, and so on.
  - out_data alternates FFFFFF/000000 inside the window and equals the input elsewhere.
  - Latency is 3 clocks.
- Clipping: ovl_x=12 on a 16-wide line. Required: only addresses 0..3 and 8..11 are issued, with rom_rd low for x>=16.
- Disable: ovl_en=0 at vs. Required: rom_rd is never high, out_data equals vid_data delayed by 3, and ovl_act=0.
- Shadowing: change ovl_x from 4 to 6 mid-frame. Required: the current frame still starts at x=4 and the next frame starts at x=6.
- Early vsync: assert vs during DRAW line 1. Required: state becomes SCAN, line_base=0, and the next frame starts again at address 0.
- Async reset mid-line: pull rst_n low for 2 clocks inside the window. Required: all outputs go to 0 immediately, and no rom_rd occurs until the vs edge that follows the release.

Source files
------------

// File: rtl/overlay_rom_sequencer.sv
// Overlay ROM sequencer: tracks the video pixel position, reads a 1-bit bitmap ROM inside a
// programmable window and substitutes expanded bitmap pixels into the delay-matched video.
module overlay_rom_sequencer #(
    parameter int unsigned OVL_W   = 64,
    parameter int unsigned OVL_H   = 32,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_de,
    input  logic              vid_hs,
    input  logic              vid_vs,
    input  logic [23:0]       vid_data,
    input  logic              ovl_en,
    input  logic [11:0]       ovl_x,
    input  logic [11:0]       ovl_y,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic              rom_q,
    output logic              out_de,
    output logic              out_hs,
    output logic              out_vs,
    output logic [23:0]       out_data,
    output logic              ovl_act
);

    localparam int unsigned       DLY_N     = ROM_LAT + 1;
    localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(OVL_W);
    localparam logic [ADDR_W-1:0] BASE_LAST = ADDR_W'((OVL_H - 1) * OVL_W);
    localparam logic [12:0]       WIN_SPAN  = 13'(OVL_W);

    typedef enum logic [1:0] {StWaitFrame, StScan, StDraw, StDone} state_e;

    typedef struct packed {
        logic        win;
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] data;
    } dly_t;

    state_e                  state_q, state_d;
    logic                    de_prev_q, vs_prev_q;
    logic [11:0]             x_q, x_d, y_q, y_d;
    logic                    sh_en_q, sh_en_d;
    logic [11:0]             sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [ADDR_W-1:0]       line_base_q, line_base_d;
    logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
    logic                    rom_rd_q, rom_rd_d;
    dly_t [DLY_N-1:0]        dly_q, dly_d;
    dly_t                    dly_tail;
    logic                    out_de_q, out_de_d, out_hs_q, out_hs_d, out_vs_q, out_vs_d;
    logic [23:0]             out_data_q, out_data_d;
    logic                    ovl_act_q, ovl_act_d;

    logic                    de_rise, de_fall, vs_rise, scan_hit, in_win;
    logic [11:0]             x_cur, x_off;
    logic [12:0]             x_ext, win_lo, win_hi;

    // Position tracking and shadow capture
    always_comb begin
        de_rise = vid_de & ~de_prev_q;
        de_fall = ~vid_de & de_prev_q;
        vs_rise = vid_vs & ~vs_prev_q;
        x_cur   = de_rise ? 12'd0 : x_q;

        x_d = x_q;
        if (vs_rise) begin
            x_d = 12'd0;
        end else if (vid_de) begin
            x_d = (x_cur == 12'hFFF) ? x_cur : x_cur + 12'd1;
        end

        y_d = y_q;
        if (vs_rise) begin
            y_d = 12'd0;
        end else if (de_fall && (y_q != 12'hFFF)) begin
            y_d = y_q + 12'd1;
        end

        sh_en_d = sh_en_q;
        sh_x_d  = sh_x_q;
        sh_y_d  = sh_y_q;
        if (vs_rise) begin
            sh_en_d = ovl_en;
            sh_x_d  = ovl_x;
            sh_y_d  = ovl_y;
        end
    end

    // Window decode and ROM address; the first pixel of the first window line is caught via
    // scan_hit so a window at column 0 is not lost to the state register delay.
    always_comb begin
        scan_hit   = (state_q == StScan) && de_rise && sh_en_q && (y_q == sh_y_q);
        x_ext      = {1'b0, x_cur};
        win_lo     = {1'b0, sh_x_q};
        win_hi     = win_lo + WIN_SPAN;
        in_win     = ((state_q == StDraw) || scan_hit) && vid_de && !vs_rise &&
                     (x_ext >= win_lo) && (x_ext < win_hi);
        x_off      = x_cur - sh_x_q;
        rom_addr_d = line_base_q + ADDR_W'(x_off);
        rom_rd_d   = in_win;
    end

    always_comb begin
        state_d     = state_q;
        line_base_d = line_base_q;
        case (state_q)
            StWaitFrame, StDone: state_d = state_q;
            StScan: begin
                if (scan_hit) begin
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (de_fall) begin
                    if (line_base_q == BASE_LAST) begin
                        state_d = StDone;
                    end else begin
                        line_base_d = line_base_q + BASE_STEP;
                    end
                end
            end
            default: state_d = StWaitFrame;
        endcase
        if (vs_rise) begin
            state_d     = StScan;
            line_base_d = '0;
        end
    end

    // Video delay line matched to the ROM read latency, then the output mux
    always_comb begin
        dly_d      = {dly_q[DLY_N-2:0], dly_t'{win: in_win, vs: vid_vs, hs: vid_hs,
                                              de: vid_de, data: vid_data}};
        dly_tail   = dly_q[DLY_N-1];
        out_de_d   = dly_tail.de;
        out_hs_d   = dly_tail.hs;
        out_vs_d   = dly_tail.vs;
        ovl_act_d  = dly_tail.win;
        out_data_d = dly_tail.win ? {24{rom_q}} : dly_tail.data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitFrame;
            de_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sh_en_q     <= 1'b0;
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            line_base_q <= '0;
            rom_addr_q  <= '0;
            rom_rd_q    <= 1'b0;
            dly_q       <= '0;
            out_de_q    <= 1'b0;
            out_hs_q    <= 1'b0;
            out_vs_q    <= 1'b0;
            out_data_q  <= '0;
            ovl_act_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            de_prev_q   <= vid_de;
            vs_prev_q   <= vid_vs;
            x_q         <= x_d;
            y_q         <= y_d;
            sh_en_q     <= sh_en_d;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            line_base_q <= line_base_d;
            rom_addr_q  <= rom_addr_d;
            rom_rd_q    <= rom_rd_d;
            dly_q       <= dly_d;
            out_de_q    <= out_de_d;
            out_hs_q    <= out_hs_d;
            out_vs_q    <= out_vs_d;
            out_data_q  <= out_data_d;
            ovl_act_q   <= ovl_act_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rom_rd   = rom_rd_q;
    assign out_de   = out_de_q;
    assign out_hs   = out_hs_q;
    assign out_vs   = out_vs_q;
    assign out_data = out_data_q;
    assign ovl_act  = ovl_act_q;

endmodule
